// File: rtl/alu_bru_unit.sv
// Integer ALU / branch-resolution unit behind a single registered AXI-Stream output stage.
// Define ALU_BRU_UNIT_MISALIGN_EN to flag misaligned redirect targets and suppress their redirect.
module alu_bru_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            invalidate,
  input  logic            s_tvalid,
  output logic            s_tready,
  input  logic            s_unit,
  input  logic [3:0]      s_funct,
  input  logic [XLEN-1:0] s_src1,
  input  logic [XLEN-1:0] s_src2,
  input  logic [XLEN-1:0] s_imm,
  input  logic [XLEN-1:0] s_pc,
  input  logic [4:0]      s_rd,
  output logic            m_tvalid,
  input  logic            m_tready,
  output logic [XLEN-1:0] m_result,
  output logic [4:0]      m_rd,
  output logic            m_redirect,
  output logic [XLEN-1:0] m_target,
  output logic            m_misalign
);

  localparam int SHW = $clog2(XLEN);

  logic            m_tvalid_q, m_tvalid_d;
  logic [XLEN-1:0] m_result_q, m_result_d;
  logic [4:0]      m_rd_q, m_rd_d;
  logic            m_redirect_q, m_redirect_d;
  logic [XLEN-1:0] m_target_q, m_target_d;
  logic            m_misalign_q, m_misalign_d;

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] jalr_target;
  logic            eq, lt, ltu;
  logic [XLEN-1:0] alu_res;
  logic            br_taken;
  logic [XLEN-1:0] nxt_result;
  logic [XLEN-1:0] nxt_target;
  logic            nxt_redirect;
  logic            nxt_misalign;
  logic            accept;
  logic            load;

  assign shamt       = s_src2[SHW-1:0];
  assign pc_plus4    = s_pc + XLEN'(4);
  assign pc_plus_imm = s_pc + s_imm;
  assign jalr_target = (s_src1 + s_imm) & {{(XLEN-1){1'b1}}, 1'b0};
  assign eq          = (s_src1 == s_src2);
  assign lt          = ($signed(s_src1) < $signed(s_src2));
  assign ltu         = (s_src1 < s_src2);

  always_comb begin
    alu_res = '0;
    case (s_funct)
      4'd0:    alu_res = s_src1 + s_src2;
      4'd1:    alu_res = s_src1 - s_src2;
      4'd2:    alu_res = s_src1 << shamt;
      4'd3:    alu_res = {{(XLEN-1){1'b0}}, lt};
      4'd4:    alu_res = {{(XLEN-1){1'b0}}, ltu};
      4'd5:    alu_res = s_src1 ^ s_src2;
      4'd6:    alu_res = s_src1 >> shamt;
      4'd7:    alu_res = $unsigned($signed(s_src1) >>> shamt);
      4'd8:    alu_res = s_src1 | s_src2;
      4'd9:    alu_res = s_src1 & s_src2;
      4'd10:   alu_res = s_src2;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (s_funct)
      4'd0:    br_taken = eq;
      4'd1:    br_taken = !eq;
      4'd4:    br_taken = lt;
      4'd5:    br_taken = !lt;
      4'd6:    br_taken = ltu;
      4'd7:    br_taken = !ltu;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    nxt_result   = alu_res;
    nxt_target   = pc_plus4;
    nxt_redirect = 1'b0;
    nxt_misalign = 1'b0;
    if (s_unit) begin
      if (s_funct == 4'd8) begin
        nxt_result   = pc_plus4;
        nxt_target   = pc_plus_imm;
        nxt_redirect = 1'b1;
      end else if (s_funct == 4'd9) begin
        nxt_result   = pc_plus4;
        nxt_target   = jalr_target;
        nxt_redirect = 1'b1;
      end else begin
        nxt_result   = '0;
        nxt_target   = br_taken ? pc_plus_imm : pc_plus4;
        nxt_redirect = br_taken;
      end
`ifdef ALU_BRU_UNIT_MISALIGN_EN
      // A misaligned redirect is reported instead of taken; target is still exposed for the trap.
      nxt_misalign = nxt_redirect && (nxt_target[1:0] != 2'b00);
      if (nxt_misalign) nxt_redirect = 1'b0;
`endif
    end
  end

  assign s_tready = !m_tvalid_q || m_tready;
  assign accept   = s_tvalid && s_tready;
  assign load     = accept && !invalidate;

  always_comb begin
    m_tvalid_d   = m_tvalid_q;
    m_result_d   = m_result_q;
    m_rd_d       = m_rd_q;
    m_redirect_d = m_redirect_q;
    m_target_d   = m_target_q;
    m_misalign_d = m_misalign_q;
    if (invalidate)    m_tvalid_d = 1'b0;
    else if (accept)   m_tvalid_d = 1'b1;
    else if (m_tready) m_tvalid_d = 1'b0;
    if (load) begin
      m_result_d   = nxt_result;
      m_rd_d       = s_rd;
      m_redirect_d = nxt_redirect;
      m_target_d   = nxt_target;
      m_misalign_d = nxt_misalign;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tvalid_q   <= 1'b0;
      m_result_q   <= '0;
      m_rd_q       <= '0;
      m_redirect_q <= 1'b0;
      m_target_q   <= '0;
      m_misalign_q <= 1'b0;
    end else begin
      m_tvalid_q   <= m_tvalid_d;
      m_result_q   <= m_result_d;
      m_rd_q       <= m_rd_d;
      m_redirect_q <= m_redirect_d;
      m_target_q   <= m_target_d;
      m_misalign_q <= m_misalign_d;
    end
  end

  assign m_tvalid   = m_tvalid_q;
  assign m_result   = m_result_q;
  assign m_rd       = m_rd_q;
  assign m_redirect = m_redirect_q;
  assign m_target   = m_target_q;
  assign m_misalign = m_misalign_q;

endmodule

// File: tb/tb_alu_bru_unit.sv
// Directed-vector bench for alu_bru_unit: ALU/BRU results, backpressure, flush and reset.
module tb_alu_bru_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        invalidate;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_unit;
  logic [3:0]  s_funct;
  logic [31:0] s_src1, s_src2, s_imm, s_pc;
  logic [4:0]  s_rd;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_result;
  logic [4:0]  m_rd;
  logic        m_redirect;
  logic [31:0] m_target;
  logic        m_misalign;

  int total = 0;
  int bad   = 0;

  alu_bru_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .invalidate(invalidate),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_unit(s_unit), .s_funct(s_funct),
    .s_src1(s_src1), .s_src2(s_src2), .s_imm(s_imm), .s_pc(s_pc), .s_rd(s_rd),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_result(m_result), .m_rd(m_rd),
    .m_redirect(m_redirect), .m_target(m_target), .m_misalign(m_misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  task automatic present(input logic unit, input logic [3:0] funct, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                         input logic [4:0] rd);
    s_tvalid = 1'b1;
    s_unit   = unit;
    s_funct  = funct;
    s_src1   = a;
    s_src2   = b;
    s_imm    = imm;
    s_pc     = pc;
    s_rd     = rd;
  endtask

  task automatic run_vec(input string tag, input logic unit, input logic [3:0] funct,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [4:0] rd,
                         input logic [31:0] e_res, input logic [31:0] e_tgt,
                         input logic e_redir, input logic e_mis);
    present(unit, funct, a, b, imm, pc, rd);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    check({tag, ".valid"}, {31'b0, m_tvalid}, 32'd1);
    check({tag, ".result"}, m_result, e_res);
    check({tag, ".rd"}, {27'b0, m_rd}, {27'b0, rd});
    check({tag, ".target"}, m_target, e_tgt);
    check({tag, ".redirect"}, {31'b0, m_redirect}, {31'b0, e_redir});
    check({tag, ".misalign"}, {31'b0, m_misalign}, {31'b0, e_mis});
  endtask

  initial begin
    rst = 1'b1; invalidate = 1'b0; m_tready = 1'b1;
    s_tvalid = 1'b0; s_unit = 1'b0; s_funct = '0;
    s_src1 = '0; s_src2 = '0; s_imm = '0; s_pc = '0; s_rd = '0;
    #3;
    check("rst.valid", {31'b0, m_tvalid}, 32'd0);
    check("rst.ready", {31'b0, s_tready}, 32'd1);
    check("rst.result", m_result, 32'd0);
    check("rst.rd", {27'b0, m_rd}, 32'd0);
    check("rst.target", m_target, 32'd0);
    check("rst.redirect", {31'b0, m_redirect}, 32'd0);
    check("rst.misalign", {31'b0, m_misalign}, 32'd0);
    #4 rst = 1'b0;
    @(posedge clk); #1;

    // ALU ops: target pc+4, no redirect
    run_vec("add_wrap", 0, 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h10, 5'd1, 32'h0, 32'h14, 0, 0);
    run_vec("sub", 0, 4'd1, 32'd5, 32'd7, 32'd0, 32'h10, 5'd2, 32'hFFFF_FFFE, 32'h14, 0, 0);
    run_vec("sll_mask", 0, 4'd2, 32'd1, 32'd33, 32'd0, 32'h0, 5'd3, 32'd2, 32'h4, 0, 0);
    run_vec("slt", 0, 4'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 5'd4, 32'd1, 32'h4, 0, 0);
    run_vec("sltu", 0, 4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 5'd5, 32'd0, 32'h4, 0, 0);
    run_vec("xor", 0, 4'd5, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 32'h0, 5'd6, 32'hFF00_EDCB, 32'h4, 0, 0);
    run_vec("srl", 0, 4'd6, 32'h8000_0000, 32'd4, 32'd0, 32'h0, 5'd7, 32'h0800_0000, 32'h4, 0, 0);
    run_vec("sra", 0, 4'd7, 32'h8000_0000, 32'd4, 32'd0, 32'h0, 5'd8, 32'hF800_0000, 32'h4, 0, 0);
    run_vec("or", 0, 4'd8, 32'h0000_00F0, 32'h0000_0F0F, 32'd0, 32'h0, 5'd9, 32'h0000_0FFF, 32'h4, 0, 0);
    run_vec("and", 0, 4'd9, 32'h0000_00F0, 32'h0000_0F3F, 32'd0, 32'h0, 5'd10, 32'h0000_0030, 32'h4, 0, 0);
    run_vec("pass", 0, 4'd10, 32'h1111_1111, 32'hCAFE_F00D, 32'd0, 32'h0, 5'd11, 32'hCAFE_F00D, 32'h4, 0, 0);
    run_vec("alu_rsvd", 0, 4'd12, 32'h1234, 32'h5678, 32'd0, 32'h8, 5'd12, 32'd0, 32'hC, 0, 0);

    // BRU ops
    run_vec("beq_t", 1, 4'd0, 32'd5, 32'd5, 32'h20, 32'h100, 5'd0, 32'd0, 32'h120, 1, 0);
    run_vec("bltu_nt", 1, 4'd6, 32'd2, 32'd1, 32'h20, 32'h100, 5'd0, 32'd0, 32'h104, 0, 0);
    run_vec("bne_t", 1, 4'd1, 32'd1, 32'd2, 32'h40, 32'h100, 5'd0, 32'd0, 32'h140, 1, 0);
    run_vec("beq_back", 1, 4'd0, 32'd9, 32'd9, 32'hFFFF_FFF0, 32'h200, 5'd0, 32'd0, 32'h1F0, 1, 0);
    run_vec("blt_t", 1, 4'd4, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h100, 5'd0, 32'd0, 32'h108, 1, 0);
    run_vec("bge_nt", 1, 4'd5, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h100, 5'd0, 32'd0, 32'h104, 0, 0);
    run_vec("bgeu_t", 1, 4'd7, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h100, 5'd0, 32'd0, 32'h108, 1, 0);
    run_vec("bru_rsvd", 1, 4'd2, 32'd3, 32'd3, 32'h8, 32'h100, 5'd0, 32'd0, 32'h104, 0, 0);
    run_vec("jalr", 1, 4'd9, 32'h1001, 32'd0, 32'd0, 32'h40, 5'd1, 32'h44, 32'h1000, 1, 0);
    run_vec("jal", 1, 4'd8, 32'd0, 32'd0, 32'h80, 32'h300, 5'd1, 32'h304, 32'h380, 1, 0);
`ifdef ALU_BRU_UNIT_MISALIGN_EN
    run_vec("jal_mis", 1, 4'd8, 32'd0, 32'd0, 32'h6, 32'h0, 5'd1, 32'h4, 32'h6, 0, 1);
`else
    run_vec("jal_mis", 1, 4'd8, 32'd0, 32'd0, 32'h6, 32'h0, 5'd1, 32'h4, 32'h6, 1, 0);
`endif
    @(posedge clk); #1;
    check("drain.valid", {31'b0, m_tvalid}, 32'd0);

    // Backpressure: A held for two cycles while B waits, then both delivered in order
    m_tready = 1'b0;
    present(0, 4'd0, 32'd1, 32'd2, 32'd0, 32'h0, 5'd3);
    @(posedge clk); #1;
    present(0, 4'd1, 32'd10, 32'd4, 32'd0, 32'h0, 5'd4);
    for (int i = 0; i < 2; i++) begin
      check("stall.ready", {31'b0, s_tready}, 32'd0);
      check("stall.valid", {31'b0, m_tvalid}, 32'd1);
      check("stall.result", m_result, 32'd3);
      check("stall.rd", {27'b0, m_rd}, 32'd3);
      @(posedge clk); #1;
    end
    m_tready = 1'b1;
    #1;
    check("release.ready", {31'b0, s_tready}, 32'd1);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    check("second.valid", {31'b0, m_tvalid}, 32'd1);
    check("second.result", m_result, 32'd6);
    check("second.rd", {27'b0, m_rd}, 32'd4);
    @(posedge clk); #1;
    check("after.valid", {31'b0, m_tvalid}, 32'd0);

    // Flush while stalled with a new input pending
    m_tready = 1'b0;
    present(0, 4'd0, 32'd7, 32'd8, 32'd0, 32'h0, 5'd5);
    @(posedge clk); #1;
    present(0, 4'd0, 32'd20, 32'd22, 32'd0, 32'h0, 5'd6);
    invalidate = 1'b1;
    @(posedge clk); #1;
    invalidate = 1'b0;
    s_tvalid = 1'b0;
    check("flush_stall.valid", {31'b0, m_tvalid}, 32'd0);
    m_tready = 1'b1;
    @(posedge clk); #1;
    check("flush_stall.none", {31'b0, m_tvalid}, 32'd0);

    // Flush in the same cycle an input is accepted
    present(0, 4'd0, 32'd1, 32'd1, 32'd0, 32'h0, 5'd7);
    invalidate = 1'b1;
    #1;
    check("flush_acc.ready", {31'b0, s_tready}, 32'd1);
    @(posedge clk); #1;
    invalidate = 1'b0;
    s_tvalid = 1'b0;
    check("flush_acc.valid", {31'b0, m_tvalid}, 32'd0);
    @(posedge clk); #1;
    check("flush_acc.none", {31'b0, m_tvalid}, 32'd0);

    // Reset in the middle of a stall
    m_tready = 1'b0;
    present(0, 4'd10, 32'd0, 32'h55AA_55AA, 32'd0, 32'h0, 5'd9);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    check("pre_rst.valid", {31'b0, m_tvalid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst.valid", {31'b0, m_tvalid}, 32'd0);
    check("mid_rst.ready", {31'b0, s_tready}, 32'd1);
    check("mid_rst.result", m_result, 32'd0);
    check("mid_rst.rd", {27'b0, m_rd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_tready = 1'b1;
    @(posedge clk); #1;
    check("post_rst.valid", {31'b0, m_tvalid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
